// File: rtl/seq_stage_controller_if.sv
// Data-memory request/acknowledge channel between the SEQ stage controller and
// the data memory.
interface seq_stage_controller_if;
  logic        dmem_req;
  logic        dmem_ack;
  logic        dmem_error;
  logic [63:0] valM;

  modport master (output dmem_req, input dmem_ack, input dmem_error, input valM);
  modport slave  (input dmem_req, output dmem_ack, output dmem_error, output valM);
endinterface

// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath: one-hot stage enables,
// PC ownership, next-PC selection, data-memory handshake and status tracking.
module seq_stage_controller #(
  parameter logic [63:0] PC_RESET     = 64'd1,
  parameter int unsigned IMEM_LIMIT   = 1023,
  parameter int unsigned DMEM_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    icode,
  input  logic                          is_instruction_valid,
  input  logic                          cnd,
  input  logic [63:0]                   valC,
  input  logic [63:0]                   valP,
  seq_stage_controller_if.master        dmem,
  output logic [63:0]                   PC,
  output logic                          fetch_en,
  output logic                          decode_en,
  output logic                          execute_en,
  output logic                          wb_en,
  output logic [2:0]                    stat,
  output logic                          halted,
  output logic [31:0]                   instr_count
);

  localparam int unsigned        WAIT_W    = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(DMEM_TIMEOUT - 1);
  localparam logic [63:0]        PC_LIMIT  = 64'(IMEM_LIMIT);
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_STOP      = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [63:0]       pc_reg, pc_next;
  logic [2:0]        stat_reg, stat_next;
  logic [31:0]       count_reg, count_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [3:0]        icode_reg, icode_next;
  logic [63:0]       valc_reg, valc_next;
  logic [63:0]       valp_reg, valp_next;
  logic [63:0]       valm_reg, valm_next;
  logic              cnd_reg, cnd_next;
  logic              mem_op;
  logic [63:0]       new_pc;
  logic [4:0]        stage_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      pc_reg    <= PC_RESET;
      stat_reg  <= STAT_AOK;
      count_reg <= '0;
      wait_reg  <= '0;
      icode_reg <= '0;
      valc_reg  <= '0;
      valp_reg  <= '0;
      valm_reg  <= '0;
      cnd_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      stat_reg  <= stat_next;
      count_reg <= count_next;
      wait_reg  <= wait_next;
      icode_reg <= icode_next;
      valc_reg  <= valc_next;
      valp_reg  <= valp_next;
      valm_reg  <= valm_next;
      cnd_reg   <= cnd_next;
    end
  end

  // pushq, popq, mrmovq, rmmovq, call and ret touch data memory
  assign mem_op = icode_reg inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  always_comb begin
    new_pc = valp_reg;
    if (icode_reg == 4'h8)
      new_pc = valc_reg;
    else if (icode_reg == 4'h7 && cnd_reg)
      new_pc = valc_reg;
    else if (icode_reg == 4'h9)
      new_pc = valm_reg;
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    stat_next  = stat_reg;
    count_next = count_reg;
    wait_next  = wait_reg;
    icode_next = icode_reg;
    valc_next  = valc_reg;
    valp_next  = valp_reg;
    valm_next  = valm_reg;
    cnd_next   = cnd_reg;
    case (state_reg)
      S_FETCH: begin
        icode_next = icode;
        valc_next  = valC;
        valp_next  = valP;
        if (pc_reg > PC_LIMIT) begin
          stat_next  = STAT_ADR;
          state_next = S_STOP;
        end else if (!is_instruction_valid) begin
          stat_next  = STAT_INS;
          state_next = S_STOP;
        end else if (icode == 4'h0) begin
          stat_next  = STAT_HLT;
          state_next = S_STOP;
        end else begin
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        cnd_next   = cnd;
        wait_next  = '0;
        state_next = mem_op ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        // An ack arriving on the timeout cycle still completes the access
        if (dmem.dmem_ack) begin
          if (dmem.dmem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_STOP;
          end else begin
            valm_next  = dmem.valM;
            state_next = S_WRITEBACK;
          end
        end else if (wait_reg == WAIT_LAST) begin
          stat_next  = STAT_ADR;
          state_next = S_STOP;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      S_WRITEBACK: begin
        pc_next    = new_pc;
        count_next = count_reg + 32'd1;
        state_next = S_FETCH;
      end
      S_STOP:  state_next = S_STOP;
      default: state_next = S_FETCH;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage_en
      localparam logic [2:0] STATE_CODE = 3'(gi);
      assign stage_en[gi] = (state_reg == state_t'(STATE_CODE));
    end
  endgenerate

  assign fetch_en      = stage_en[0];
  assign decode_en     = stage_en[1];
  assign execute_en    = stage_en[2];
  assign dmem.dmem_req = stage_en[3];
  assign wb_en         = stage_en[4];
  assign PC            = pc_reg;
  assign stat          = stat_reg;
  assign halted        = (state_reg == S_STOP);
  assign instr_count   = count_reg;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Directed bench for seq_stage_controller: walks a short Y86 program and the
// fault paths, checking outputs at each falling edge.
module tb_seq_stage_controller;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode;
  logic        is_instruction_valid;
  logic        cnd;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [63:0] PC;
  logic        fetch_en, decode_en, execute_en, wb_en;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] instr_count;

  int checks   = 0;
  int failures = 0;

  seq_stage_controller_if dmem_bus ();

  seq_stage_controller dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .icode                (icode),
    .is_instruction_valid (is_instruction_valid),
    .cnd                  (cnd),
    .valC                 (valC),
    .valP                 (valP),
    .dmem                 (dmem_bus),
    .PC                   (PC),
    .fetch_en             (fetch_en),
    .decode_en            (decode_en),
    .execute_en           (execute_en),
    .wb_en                (wb_en),
    .stat                 (stat),
    .halted               (halted),
    .instr_count          (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] enables();
    return {fetch_en, decode_en, execute_en, wb_en, dmem_bus.dmem_req};
  endfunction

  initial begin
    rst_n = 1'b0;
    icode = 4'h1;
    is_instruction_valid = 1'b1;
    cnd = 1'b0;
    valC = '0;
    valP = '0;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_error = 1'b0;
    dmem_bus.valM = '0;
    step();
    step();
    chk("rst_pc", PC, 64'd1);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_en", 64'(enables()), 64'b10000);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_count", 64'(instr_count), 64'd0);

    // nop at PC=1
    icode = 4'h1; valP = 64'd2; rst_n = 1'b1;
    chk("nop_c1_fetch", 64'(enables()), 64'b10000);
    step(); chk("nop_c2_decode", 64'(enables()), 64'b01000);
    step(); chk("nop_c3_execute", 64'(enables()), 64'b00100);
    step(); chk("nop_c4_wb", 64'(enables()), 64'b00010);
    chk("nop_c4_pc", PC, 64'd1);
    step(); chk("nop_c5_fetch", 64'(enables()), 64'b10000);
    chk("nop_pc", PC, 64'd2);
    chk("nop_count", 64'(instr_count), 64'd1);

    // mrmovq, ack after three wait cycles
    icode = 4'h5; valP = 64'd11;
    step(); step();
    chk("mr_exec_req", 64'(dmem_bus.dmem_req), 64'd0);
    step(); chk("mr_m1_req", 64'(dmem_bus.dmem_req), 64'd1);
    step(); chk("mr_m2_req", 64'(dmem_bus.dmem_req), 64'd1);
    step(); chk("mr_m3_req", 64'(dmem_bus.dmem_req), 64'd1);
    step(); chk("mr_m4_req", 64'(dmem_bus.dmem_req), 64'd1);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.valM = 64'h99;
    step(); dmem_bus.dmem_ack = 1'b0;
    chk("mr_wb_en", 64'(enables()), 64'b00010);
    step(); chk("mr_pc", PC, 64'd11);
    chk("mr_count", 64'(instr_count), 64'd2);

    // call to an address above the instruction limit
    icode = 4'h8; valC = 64'h1000000000000001; valP = 64'd20;
    step(); step(); step();
    chk("call_m1_req", 64'(dmem_bus.dmem_req), 64'd1);
    dmem_bus.dmem_ack = 1'b1; dmem_bus.valM = 64'h0;
    step(); dmem_bus.dmem_ack = 1'b0;
    step(); chk("call_pc", PC, 64'h1000000000000001);
    chk("call_count", 64'(instr_count), 64'd3);
    icode = 4'h1;
    step(); chk("call_far_stat", 64'(stat), 64'd3);
    chk("call_far_halted", 64'(halted), 64'd1);
    chk("call_far_pc", PC, 64'h1000000000000001);
    chk("call_far_count", 64'(instr_count), 64'd3);
    chk("call_far_en", 64'(enables()), 64'd0);

    // ret, then jXX not taken, then jXX taken to 28, then halt
    do_reset();
    chk("rst2_pc", PC, 64'd1);
    chk("rst2_stat", 64'(stat), 64'd1);
    icode = 4'h9; valP = 64'd2;
    step(); step(); step();
    dmem_bus.dmem_ack = 1'b1; dmem_bus.valM = 64'h1B;
    step(); dmem_bus.dmem_ack = 1'b0; dmem_bus.valM = 64'h0;
    step(); chk("ret_pc", PC, 64'h1B);
    chk("ret_count", 64'(instr_count), 64'd1);
    icode = 4'h7; cnd = 1'b0; valC = 64'h500; valP = 64'h24;
    step(); step(); step();
    chk("jnt_wb_en", 64'(enables()), 64'b00010);
    step(); chk("jnt_pc", PC, 64'h24);
    icode = 4'h7; cnd = 1'b1; valC = 64'd28; valP = 64'h2D;
    step(); step(); step(); step();
    cnd = 1'b0;
    chk("jt_pc", PC, 64'd28);
    chk("jt_count", 64'(instr_count), 64'd3);
    icode = 4'h0;
    step(); chk("hlt_stat", 64'(stat), 64'd2);
    chk("hlt_halted", 64'(halted), 64'd1);
    chk("hlt_pc", PC, 64'd28);
    chk("hlt_en", 64'(enables()), 64'd0);
    step(); chk("hlt_en_later", 64'(enables()), 64'd0);
    chk("hlt_count", 64'(instr_count), 64'd3);

    // invalid instruction
    icode = 4'h1;
    do_reset();
    is_instruction_valid = 1'b0;
    step(); is_instruction_valid = 1'b1;
    chk("ins_stat", 64'(stat), 64'd4);
    chk("ins_pc", PC, 64'd1);

    // limit boundary: 1023 legal, 1024 address error
    do_reset();
    icode = 4'h7; cnd = 1'b1; valC = 64'd1023; valP = 64'd5;
    step(); step(); step(); step();
    cnd = 1'b0; icode = 4'h1; valP = 64'd1024;
    chk("lim_pc_1023", PC, 64'd1023);
    step(); chk("lim_1023_decode", 64'(enables()), 64'b01000);
    step(); step(); step();
    chk("lim_pc_1024", PC, 64'd1024);
    step(); chk("lim_stat", 64'(stat), 64'd3);
    chk("lim_pc_hold", PC, 64'd1024);
    chk("lim_count", 64'(instr_count), 64'd2);

    // pushq with no ack: timeout after 15 MEMORY cycles
    do_reset();
    icode = 4'hA; valP = 64'd10;
    step(); step();
    for (int i = 0; i < 15; i++) begin
      step(); chk($sformatf("to_req_m%0d", i + 1), 64'(dmem_bus.dmem_req), 64'd1);
    end
    step(); chk("to_req_off", 64'(dmem_bus.dmem_req), 64'd0);
    chk("to_stat", 64'(stat), 64'd3);
    chk("to_halted", 64'(halted), 64'd1);
    chk("to_pc", PC, 64'd1);

    // stray ack outside MEMORY, then asynchronous reset mid-MEMORY
    do_reset();
    icode = 4'h1; valP = 64'd2;
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_error = 1'b1;
    step(); dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_error = 1'b0;
    chk("stray_ack_decode", 64'(enables()), 64'b01000);
    step(); step(); step();
    chk("stray_ack_pc", PC, 64'd2);
    icode = 4'hA; valP = 64'd12;
    step(); step(); step();
    chk("async_pre_req", 64'(dmem_bus.dmem_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 64'(dmem_bus.dmem_req), 64'd0);
    chk("async_en", 64'(enables()), 64'b10000);
    chk("async_pc", PC, 64'd1);
    chk("async_stat", 64'(stat), 64'd1);
    chk("async_count", 64'(instr_count), 64'd0);
    step(); rst_n = 1'b1;

    // nop, then pushq with ack carrying an error
    icode = 4'h1; valP = 64'd2;
    step(); step(); step(); step();
    icode = 4'hA; valP = 64'd12;
    step(); step(); step(); step();
    dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_error = 1'b1;
    step(); dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_error = 1'b0;
    chk("err_stat", 64'(stat), 64'd3);
    chk("err_halted", 64'(halted), 64'd1);
    chk("err_pc", PC, 64'd2);
    chk("err_count", 64'(instr_count), 64'd1);
    chk("err_req", 64'(dmem_bus.dmem_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_stage_controller.md
# seq_stage_controller

Multi-cycle stage sequencer for the Y86-64 SEQ datapath. It drives one-hot stage enables (fetch, decode, execute, memory, writeback) to the existing fetch and decode/writeback blocks, owns the PC register, and selects the next PC. It handles the data-memory request/acknowledge handshake and maintains the Y86 status code. The block replaces free-running `PC <= valP` sequencing with explicit halt, invalid-instruction and address-error handling.

## Interface
- `PC_RESET`, default 64'd1: PC value loaded on reset.
- `IMEM_LIMIT`, default 1023: highest legal instruction address.
- `DMEM_TIMEOUT`, default 15: maximum wait cycles in MEMORY before an address error.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `icode`  in  4  instruction code from fetch.
- `is_instruction_valid`  in  1  fetch decode-legal flag.
- `cnd`  in  1  condition result from execute.
- `valC`  in  64  constant word from fetch.
- `valP`  in  64  fall-through PC from fetch.
- `valM`  in  64  data-memory read value.
- `dmem_ack`  in  1  data-memory completion; one-cycle pulse.
- `dmem_error`  in  1  data-memory fault; sampled only with `dmem_ack`.
- `PC`  out  64  current program counter.
- `fetch_en`, `decode_en`, `execute_en`, `wb_en`  out  1 each  stage enables.
- `dmem_req`  out  1  data-memory request; level signal.
- `stat`  out  3  status code: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `halted`  out  1  high in STOP.
- `instr_count`  out  32  count of retired instructions.

## Operation
- FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, STOP.
- Stage enables are Moore outputs, exactly one high per state. `dmem_req` is the MEMORY enable. No enable is high in STOP.
- **FETCH:** register `icode_q`, `valC_q` and `valP_q`. Checks run in this priority order:
  - `PC > IMEM_LIMIT` → `stat` = 3, go to STOP.
  - `!is_instruction_valid` → `stat` = 4, go to STOP.
  - `icode` = 0 → `stat` = 2, go to STOP.
  - Otherwise go to DECODE.
- **DECODE:** go to EXECUTE.
- **EXECUTE:** register `cnd_q`. If `icode_q` is in {4,5,8,9,A,B}, go to MEMORY; otherwise go to WRITEBACK.
- **MEMORY:** hold `dmem_req` high and count wait cycles.
  - `dmem_ack` with `!dmem_error` → register `valM_q`, go to WRITEBACK.
  - `dmem_ack` with `dmem_error` → `stat` = 3, go to STOP.
  - Wait count reaching `DMEM_TIMEOUT` with no ack → `stat` = 3, go to STOP.
- **WRITEBACK:** update PC, increment `instr_count`, go to FETCH. Next-PC selection:
  - `icode_q` = 8 (call) → `valC_q`.
  - `icode_q` = 7 (jXX) and `cnd_q` → `valC_q`.
  - `icode_q` = 9 (ret) → `valM_q`.
  - Otherwise → `valP_q`.
- **STOP:** terminal state. PC and `instr_count` are frozen; only reset exits it.
- **Arithmetic:**
  - PC is unsigned 64-bit.
  - The limit comparison is unsigned.
  - `instr_count` wraps modulo 2^32.
  - The wait counter is `clog2(DMEM_TIMEOUT+1)` bits, cleared on MEMORY entry.
- **Faults:** a faulting instruction does not retire. PC stays at the faulting instruction and `instr_count` does not increment.

## Timing
- **Reset values:** state = FETCH, `PC` = `PC_RESET`, `stat` = 1, `fetch_en` = 1, all other enables 0, `dmem_req` = 0, `halted` = 0, `instr_count` = 0.
- **Reset assertion:** reset takes effect asynchronously in any state. In particular, `dmem_req` drops in the same cycle `rst_n` falls, even mid-MEMORY.
- **Reset release:** the first FETCH begins on the first rising edge after `rst_n` rises.
- **Latency:**
  - Non-memory instruction: 4 cycles (F, D, E, W).
  - Memory instruction: 5 + N cycles, where N is the number of cycles `dmem_req` is high before `dmem_ack`. N = 0 means ack in the first MEMORY cycle.
- **PC update:** the new `PC` is visible in the cycle after WRITEBACK, which is the next FETCH cycle.
- **Handshake:**
  - `dmem_req` rises on MEMORY entry and falls on the cycle after `dmem_ack`.
  - An ack outside MEMORY is ignored.
  - A simultaneous ack and timeout counts as ack.
- **Fault detection:** detection in FETCH or MEMORY sets `stat` and `halted` one cycle later.

## Test plan
1. Pulse `rst_n` low mid-run → `PC` = 1, `stat` = 1, `fetch_en` = 1, `instr_count` = 0 immediately, with no clock edge required.
2. nop at PC=1 (`icode` = 1, `valP` = 2) → `wb_en` high exactly once in cycle 4; `PC` = 2 and `instr_count` = 1 in cycle 5.
3. mrmovq (`icode` = 5, `valP` = 11) with `dmem_ack` after 3 wait cycles → `dmem_req` high for 4 cycles; `PC` = 11 after 8 cycles total.
4. call with `valC` = 0x1000000000000001 → `PC` = 0x1000000000000001. Then ret with `valM` = 0x1B → `PC` = 0x1B. Then jXX with `cnd` = 0 and `valP` = 0x24 → `PC` = 0x24.
5. Three fault cases:
   - halt (`icode` = 0) at PC=28 → `stat` = 2, `halted` = 1, `PC` stays 28, no enables afterward.
   - `is_instruction_valid` = 0 → `stat` = 4.
   - `PC` = 1024 → `stat` = 3.
6. pushq with no `dmem_ack` → `stat` = 3 after exactly 15 MEMORY cycles. Repeat with `dmem_ack` and `dmem_error` → `stat` = 3, `instr_count` unchanged.
